// File: rtl/gbe_stream_arbiter_if.sv
// Handshake bundle between the requester streams, the arbiter and the GbE TX side.
// The arbiter uses the slave modport; the requester/TX model uses master.
interface gbe_stream_arbiter_if #(
  parameter int N_STREAMS  = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int GW = $clog2(N_STREAMS);

  logic [N_STREAMS*DATA_WIDTH-1:0] din;
  logic [N_STREAMS-1:0]            din_valid;
  logic [N_STREAMS-1:0]            din_ready;
  logic [N_STREAMS-1:0]            stream_en;
  logic [DATA_WIDTH-1:0]           dout;
  logic                            dout_valid;
  logic                            dout_eof;
  logic                            dout_ready;
  logic [GW-1:0]                   grant_id;
  logic                            busy;
  logic                            pkt_done;

  modport master (
    output din, din_valid, stream_en, dout_ready,
    input  din_ready, dout, dout_valid, dout_eof, grant_id, busy, pkt_done
  );

  modport slave (
    input  din, din_valid, stream_en, dout_ready,
    output din_ready, dout, dout_valid, dout_eof, grant_id, busy, pkt_done
  );
endinterface

// File: rtl/gbe_stream_arbiter.sv
// Round-robin packetiser: picks one requester stream, emits a header word, PKT_WORDS
// payload words passed through with zero latency, then GAP_CYCLES idle cycles.
module gbe_stream_arbiter #(
  parameter int          N_STREAMS  = 4,
  parameter int          DATA_WIDTH = 64,
  parameter int          PKT_WORDS  = 128,
  parameter int          GAP_CYCLES = 4,
  parameter logic [31:0] SEQ_INIT   = '0   // reset value of every per-stream sequence number
) (
  input logic            clk,
  input logic            rst,
  gbe_stream_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_STREAMS);
  localparam logic [15:0] LAST_WORD = 16'(PKT_WORDS - 1);
  localparam logic [7:0]  GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, last_q, pick, cand;
  logic                  any_elig;
  logic [N_STREAMS-1:0]  elig;
  logic [31:0]           seq_q [N_STREAMS];
  logic [15:0]           word_cnt_q;
  logic [7:0]            gap_q;
  logic                  is_last, out_xfer;
  logic [DATA_WIDTH-1:0] header;

  // Round-robin search starting one past the stream that last finished a packet
  always_comb begin
    elig     = bus.din_valid & bus.stream_en;
    pick     = '0;
    cand     = '0;
    any_elig = 1'b0;
    for (int unsigned k = 1; k <= N_STREAMS; k++) begin
      cand = GW'((32'(last_q) + k) % N_STREAMS);
      if (!any_elig && elig[cand]) begin
        pick     = cand;
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    header                     = '0;
    header[DATA_WIDTH-1 -: 8]  = 8'(grant_q);
    header[47:32]              = 16'(PKT_WORDS);
    header[31:0]               = seq_q[grant_q];
  end

  assign is_last = (word_cnt_q == LAST_WORD);

  always_comb begin
    state_d        = state_q;
    bus.dout       = '0;
    bus.dout_valid = 1'b0;
    bus.dout_eof   = 1'b0;
    bus.din_ready  = '0;
    bus.pkt_done   = 1'b0;
    out_xfer       = 1'b0;
    unique case (state_q)
      S_IDLE: if (any_elig) state_d = S_HEADER;
      S_HEADER: begin
        bus.dout       = header;
        bus.dout_valid = 1'b1;
        out_xfer       = bus.dout_ready;
        if (bus.dout_ready) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        bus.dout               = bus.din[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        bus.dout_valid         = bus.din_valid[grant_q];
        bus.dout_eof           = is_last;
        bus.din_ready[grant_q] = bus.dout_ready;
        out_xfer               = bus.din_valid[grant_q] & bus.dout_ready;
        if (out_xfer && is_last) begin
          bus.pkt_done = 1'b1;
          state_d      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: if (gap_q == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= GW'(N_STREAMS - 1);
      word_cnt_q <= '0;
      gap_q      <= '0;
      for (int unsigned i = 0; i < N_STREAMS; i++) seq_q[i] <= SEQ_INIT;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE:   if (any_elig) grant_q <= pick;
        S_HEADER: if (out_xfer) word_cnt_q <= '0;
        S_PAYLOAD: begin
          if (out_xfer) begin
            if (is_last) begin
              word_cnt_q     <= '0;
              last_q         <= grant_q;
              seq_q[grant_q] <= seq_q[grant_q] + 32'd1;
              gap_q          <= '0;
            end else begin
              word_cnt_q <= word_cnt_q + 16'd1;
            end
          end
        end
        S_GAP:   gap_q <= gap_q + 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_gbe_stream_arbiter.sv
// Scoreboard bench for gbe_stream_arbiter: source queues feed the streams, expected
// header/payload words are queued at load time and popped on each output transfer.
module tb_gbe_stream_arbiter;
  localparam int NS  = 4;
  localparam int DW  = 64;
  localparam int PKT = 4;
  localparam int GAP = 2;

  typedef struct packed {
    logic [63:0] data;
    logic        eof;
    logic        hdr;
  } exp_t;

  logic clk;
  logic rst;

  gbe_stream_arbiter_if #(.N_STREAMS(NS), .DATA_WIDTH(DW)) bus ();
  gbe_stream_arbiter_if #(.N_STREAMS(NS), .DATA_WIDTH(DW)) bus_w ();

  gbe_stream_arbiter #(.N_STREAMS(NS), .DATA_WIDTH(DW), .PKT_WORDS(PKT), .GAP_CYCLES(GAP))
    dut (.clk(clk), .rst(rst), .bus(bus));

  gbe_stream_arbiter #(.N_STREAMS(NS), .DATA_WIDTH(DW), .PKT_WORDS(PKT), .GAP_CYCLES(GAP),
                       .SEQ_INIT(32'hFFFF_FFFF))
    dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] src_q [NS][$];
  exp_t        exp_q [$];
  logic [NS-1:0] acc;
  logic        o_xfer;
  bit          rand_ready, rand_gaps;

  function automatic logic [63:0] wd(int s, int k);
    return {16'hDA7A, 16'(s), 32'(k)};
  endfunction

  function automatic logic [63:0] hdr(int s, logic [31:0] seq);
    return {8'(s), 8'h00, 16'(PKT), seq};
  endfunction

  task automatic load(int s, int k0, int n);
    for (int k = k0; k < k0 + n; k++) src_q[s].push_back(wd(s, k));
  endtask

  task automatic push_hdr(int s, logic [31:0] seq);
    exp_t e;
    e.data = hdr(s, seq); e.eof = 1'b0; e.hdr = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_words(int s, int k0, int n, bit eof_last);
    exp_t e;
    for (int k = k0; k < k0 + n; k++) begin
      e.data = wd(s, k); e.eof = eof_last && (k == k0 + n - 1); e.hdr = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // One clock: retire accepted source words, drive the next stimulus, sample at negedge
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NS; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    #1;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
        bus.din[i*DW +: DW] = src_q[i][0];
        bus.din_valid[i]    = 1'b1;
      end else begin
        bus.din_valid[i] = 1'b0;
      end
    end
    bus.dout_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(negedge clk);
    acc    = bus.din_valid & bus.din_ready;
    o_xfer = bus.dout_valid & bus.dout_ready;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    acc = '0;
    rand_ready = 0;
    rand_gaps  = 0;
    bus.stream_en = '1;
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.din = '1;
    bus.din_valid = '1;
    bus.stream_en = '1;
    bus.dout_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dout_valid: got %b want 0", bus.dout_valid); end
    n_cmp++; if (bus.dout_eof !== 1'b0) begin n_bad++; $display("FAIL rst_dout_eof: got %b want 0", bus.dout_eof); end
    n_cmp++; if (bus.din_ready !== 4'b0) begin n_bad++; $display("FAIL rst_din_ready: got %b want 0000", bus.din_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.pkt_done !== 1'b0) begin n_bad++; $display("FAIL rst_pkt_done: got %b want 0", bus.pkt_done); end
    n_cmp++; if (bus.dout !== 64'h0) begin n_bad++; $display("FAIL rst_dout: got %h want 0", bus.dout); end
    n_cmp++; if (bus.grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant_id: got %0d want 0", bus.grant_id); end
    bus.din_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_rst: busy=%b valid=%b want 0 0", bus.busy, bus.dout_valid);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int done_cnt = 0, idle = 0;
    bit counting = 0;
    do_reset();
    load(1, 0, 8);
    push_hdr(1, 32'd0); push_words(1, 0, PKT, 1);
    push_hdr(1, 32'd1); push_words(1, PKT, PKT, 1);
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      tick();
      if (counting) begin
        if (bus.dout_valid) begin
          counting = 0;
          n_cmp++; if (idle != GAP + 1) begin n_bad++; $display("FAIL single_gap: got %0d idle cycles want %0d", idle, GAP + 1); end
        end else idle++;
      end
      n_cmp++;
      if (bus.pkt_done !== (o_xfer && exp_q[0].eof)) begin
        n_bad++; $display("FAIL single_pkt_done: got %b want %b", bus.pkt_done, o_xfer && exp_q[0].eof);
      end
      if (bus.pkt_done) done_cnt++;
      if (o_xfer) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.dout !== e.data || bus.dout_eof !== e.eof) begin
          n_bad++; $display("FAIL single_word: got %h eof=%b want %h eof=%b", bus.dout, bus.dout_eof, e.data, e.eof);
        end
        if (e.hdr) begin
          n_cmp++; if (bus.grant_id !== 2'd1) begin n_bad++; $display("FAIL single_grant: got %0d want 1", bus.grant_id); end
        end
        if (e.eof) begin counting = 1; idle = 0; end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL single_timeout: got %0d left want 0", exp_q.size()); end
    n_cmp++; if (done_cnt != 2) begin n_bad++; $display("FAIL single_done_count: got %0d want 2", done_cnt); end
  endtask

  task automatic test_rr();
    exp_t e;
    do_reset();
    for (int s = 0; s < NS; s++) load(s, 0, 2 * PKT);
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NS; s++) begin
        push_hdr(s, 32'(r)); push_words(s, r * PKT, PKT, 1);
      end
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      tick();
      if (o_xfer) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.dout !== e.data || bus.dout_eof !== e.eof) begin
          n_bad++; $display("FAIL rr_word: got %h eof=%b want %h eof=%b", bus.dout, bus.dout_eof, e.data, e.eof);
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_enable_mask();
    exp_t e;
    do_reset();
    bus.stream_en = 4'b1011;
    for (int s = 0; s < NS; s++) load(s, 0, PKT);
    foreach (bus.stream_en[s]) ;
    push_hdr(0, 32'd0); push_words(0, 0, PKT, 1);
    push_hdr(1, 32'd0); push_words(1, 0, PKT, 1);
    push_hdr(3, 32'd0); push_words(3, 0, PKT, 1);
    for (int c = 0; c < 120 && exp_q.size() > 0; c++) begin
      tick();
      n_cmp++; if (bus.din_ready[2] !== 1'b0) begin n_bad++; $display("FAIL en_ready2: got %b want 0", bus.din_ready[2]); end
      if (o_xfer) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.dout !== e.data || bus.dout_eof !== e.eof) begin
          n_bad++; $display("FAIL en_word: got %h eof=%b want %h eof=%b", bus.dout, bus.dout_eof, e.data, e.eof);
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL en_timeout: got %0d left want 0", exp_q.size()); end
    for (int c = 0; c < 10; c++) tick();
    n_cmp++; if (src_q[2].size() != PKT) begin n_bad++; $display("FAIL en_stream2_untouched: got %0d words left want %0d", src_q[2].size(), PKT); end
  endtask

  task automatic test_stall();
    exp_t e;
    bit prev_stall = 0;
    logic [63:0] prev_dout = '0;
    do_reset();
    rand_ready = 1;
    rand_gaps  = 1;
    load(3, 0, 3 * PKT);
    for (int p = 0; p < 3; p++) begin
      push_hdr(3, 32'(p)); push_words(3, p * PKT, PKT, 1);
    end
    for (int c = 0; c < 800 && exp_q.size() > 0; c++) begin
      tick();
      if (prev_stall) begin
        n_cmp++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== prev_dout) begin
          n_bad++; $display("FAIL stall_hdr_stable: got %h valid=%b want %h valid=1", bus.dout, bus.dout_valid, prev_dout);
        end
      end
      prev_stall = bus.dout_valid && !bus.dout_ready && exp_q[0].hdr;
      prev_dout  = bus.dout;
      if (o_xfer) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.dout !== e.data || bus.dout_eof !== e.eof) begin
          n_bad++; $display("FAIL stall_word: got %h eof=%b want %h eof=%b", bus.dout, bus.dout_eof, e.data, e.eof);
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_timeout: got %0d left want 0", exp_q.size()); end
    rand_ready = 0;
    rand_gaps  = 0;
  endtask

  task automatic test_seq_wrap();
    logic [63:0] w_exp [$];
    logic [63:0] w;
    bit w_hdr = 1;
    do_reset();
    w_exp.push_back(hdr(0, 32'hFFFF_FFFF));
    w_exp.push_back(hdr(0, 32'h0000_0000));
    w_exp.push_back(hdr(0, 32'h0000_0001));
    for (int c = 0; c < 100 && w_exp.size() > 0; c++) begin
      tick();
      if (bus_w.dout_valid && bus_w.dout_ready) begin
        if (w_hdr) begin
          w = w_exp.pop_front();
          n_cmp++;
          if (bus_w.dout !== w) begin n_bad++; $display("FAIL wrap_header: got %h want %h", bus_w.dout, w); end
        end
        w_hdr = bus_w.dout_eof;
      end
    end
    n_cmp++; if (w_exp.size() != 0) begin n_bad++; $display("FAIL wrap_timeout: got %0d left want 0", w_exp.size()); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    load(0, 0, 10);
    push_hdr(0, 32'd0); push_words(0, 0, PKT, 1);
    push_hdr(0, 32'd1); push_words(0, PKT, 2, 0);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      tick();
      if (o_xfer) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.dout !== e.data || bus.dout_eof !== e.eof) begin
          n_bad++; $display("FAIL rmid_pre_word: got %h eof=%b want %h eof=%b", bus.dout, bus.dout_eof, e.data, e.eof);
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rmid_pre_timeout: got %0d left want 0", exp_q.size()); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.din_ready !== 4'b0 || bus.dout !== 64'h0 ||
        bus.dout_eof !== 1'b0 || bus.pkt_done !== 1'b0 || bus.grant_id !== 2'd0) begin
      n_bad++; $display("FAIL rmid_reset_outputs: got valid=%b busy=%b rdy=%b dout=%h eof=%b done=%b gid=%0d want all 0",
                        bus.dout_valid, bus.busy, bus.din_ready, bus.dout, bus.dout_eof, bus.pkt_done, bus.grant_id);
    end
    rst = 1'b1;
    push_hdr(0, 32'd0); push_words(0, PKT + 2, PKT, 1);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      tick();
      if (o_xfer) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.dout !== e.data || bus.dout_eof !== e.eof) begin
          n_bad++; $display("FAIL rmid_post_word: got %h eof=%b want %h eof=%b", bus.dout, bus.dout_eof, e.data, e.eof);
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rmid_post_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b0;
    acc = '0;
    o_xfer = 1'b0;
    rand_ready = 0;
    rand_gaps  = 0;
    bus.din = '0;
    bus.din_valid = '0;
    bus.stream_en = '1;
    bus.dout_ready = 1'b0;
    bus_w.din = {NS{64'h1234_5678_9ABC_DEF0}};
    bus_w.din_valid = 4'b0001;
    bus_w.stream_en = '1;
    bus_w.dout_ready = 1'b1;
    test_reset();
    test_single();
    test_rr();
    test_enable_mask();
    test_stall();
    test_seq_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gbe_stream_arbiter.md
GBE_STREAM_ARBITER -- requirements
Module: gbe_stream_arbiter

Interface
REQ-001 Parameter N_STREAMS, default 4: number of serialized requester streams (2..8).
REQ-002 Parameter DATA_WIDTH, default 64: word width (SHALL be >= 64).
REQ-003 Parameter PKT_WORDS, default 128: payload words per packet (2..65535).
REQ-004 Parameter GAP_CYCLES, default 4: idle cycles forced after each packet (0..255).
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-low reset (rst=0 resets on the next clk edge).
REQ-007 din  in  N_STREAMS*DATA_WIDTH  stream i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 din_valid  in  N_STREAMS  per-stream valid.
REQ-009 din_ready  out  N_STREAMS  per-stream ready.
REQ-010 stream_en  in  N_STREAMS  per-stream arbitration enable.
REQ-011 dout  out  DATA_WIDTH  packet word to the GbE TX interface.
REQ-012 dout_valid  out  1  dout holds a valid word.
REQ-013 dout_eof  out  1  marks the last word of a packet; qualified by dout_valid.
REQ-014 dout_ready  in  1  downstream accepts the word this cycle.
REQ-015 grant_id  out  $clog2(N_STREAMS)  stream currently owning the output.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 pkt_done  out  1  one-cycle pulse on the cycle the eof word transfers.

Function
REQ-018 Transfer: a word moves on a cycle where dout_valid=1 and dout_ready=1; on the payload side, when din_valid[g]=1 and din_ready[g]=1.
REQ-019 FSM states: IDLE, HEADER, PAYLOAD, GAP.
REQ-020 Eligibility: stream i is eligible when din_valid[i]=1 and stream_en[i]=1.
REQ-021 IDLE: if any stream is eligible, grant the first eligible stream in round-robin order starting at last_grant+1 (mod N_STREAMS), latch it into grant_id, and go to HEADER next cycle; otherwise stay in IDLE.
REQ-022 Grant: grant_id is held constant from HEADER through GAP, and last_grant updates when the eof word transfers.
REQ-023 HEADER: dout_valid=1, dout_eof=0, and dout={grant_id zero-extended into [DATA_WIDTH-1:DATA_WIDTH-8], zeros, PKT_WORDS[15:0] in [47:32], seq[grant_id] in [31:0]}; the header is held stable until transfer, and on transfer the FSM goes to PAYLOAD with word_cnt=0.
REQ-024 PAYLOAD: dout=din[grant_id], dout_valid=din_valid[grant_id], din_ready[grant_id]=dout_ready (combinational, zero latency), and every other din_ready bit is 0.
REQ-025 PAYLOAD: word_cnt increments on each transfer; dout_eof = (word_cnt==PKT_WORDS-1).
REQ-026 On eof transfer: pulse pkt_done, increment seq[grant_id] (32-bit, wrapping 0xFFFFFFFF->0), and go to GAP (to IDLE directly when GAP_CYCLES=0).
REQ-027 GAP: outputs idle (dout_valid=0, din_ready=0) for exactly GAP_CYCLES cycles, then IDLE.
REQ-028 din_valid[grant_id] dropping mid-packet stalls the packet indefinitely with grant kept; there is no timeout and no abort.
REQ-029 stream_en[grant_id] deasserting mid-packet does not affect the current packet; it only takes effect at the next arbitration.
REQ-030 Outside PAYLOAD, all din_ready bits are 0; in IDLE and GAP, dout_valid=0 and dout_eof=0.
REQ-031 dout_ready=0 in HEADER or PAYLOAD back-pressures with no data loss and no counter change.

Reset
REQ-032 On rst=0, the following take effect at the next edge: state=IDLE, grant_id=0, last_grant=N_STREAMS-1 (so stream 0 has first priority), all seq=0, word_cnt=0, gap counter=0.
REQ-033 During and after reset, until the first grant: dout_valid=0, dout_eof=0, din_ready=0, busy=0, pkt_done=0, dout=0.
REQ-034 Reset asserted mid-packet truncates the packet without eof; the next packet after reset starts with a header and seq=0.

Verification
REQ-035 PKT_WORDS=4, GAP=2, only stream 1 valid, dout_ready=1 -> header seq=0 with id=1, then 4 payload words with eof on the 4th, pkt_done pulses once, 2 idle cycles, next header seq=1.
REQ-036 All 4 streams valid and enabled continuously -> grant order 0,1,2,3,0, and each stream's seq increments by 1 per packet it owns.
REQ-037 stream_en=4'b1011 with all streams valid -> stream 2 is never granted and din_ready[2] stays 0.
REQ-038 Random dout_ready and random din_valid[g] gaps -> payload words are delivered in order with none lost or duplicated, and the header stays stable while stalled.
REQ-039 seq[0] preloaded near wrap: after a packet with seq=0xFFFFFFFF, the next header of stream 0 carries seq=0.
REQ-040 rst=0 pulsed after 2 payload words -> outputs at reset values next cycle, and the following packet starts with a header carrying seq=0.
